// File: rtl/lsu_controller.sv
// lsu_controller
// Sequencing controller between the execute/memory stage and a single-outstanding
// valid/ready data-memory bus. One load or store is accepted per handshake. Store
// data is replicated onto the byte lanes and load data is extracted and extended.
// Misaligned accesses and bus timeouts complete with an error response.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    core request handshake (ready only while idle)
//   req_funct3               RV32I load/store funct3
//   req_addr, req_wdata      byte address, right-justified store data
//   req_wstrobe              decoded byte-lane mask
//   req_wen, req_ren         store / load enables
//   mem_valid / mem_ready    bus handshake (mem_rdata valid with mem_ready)
//   mem_addr, mem_we         word-aligned address, write enable
//   mem_wstrb, mem_wdata     byte lanes, lane-aligned store data
//   mem_rdata                read word
//   rsp_valid                one-cycle completion pulse
//   rsp_rdata, rsp_err       extended load result, error flag
//   busy                     pipeline stall (controller not idle)
module lsu_controller #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrobe,
    input  logic        req_wen,
    input  logic        req_ren,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic [3:0]    wstrb_reg, wstrb_next;
    logic          wen_reg, wen_next;
    logic [1:0]    size_reg, size_next;
    logic          uns_reg, uns_next;
    logic [31:0]   rdata_reg, rdata_next;
    logic          err_reg, err_next;

    // Request decode. Only the enumerated funct3 codes for the selected
    // direction select byte/half; anything else is handled as a word.
    logic [1:0]  size_in;
    logic        uns_in;
    logic        misal_in;
    logic [31:0] wdata_aligned;

    always_comb begin
        size_in = SZ_W;
        if (req_wen) begin
            case (req_funct3)
                3'b000:  size_in = SZ_B;
                3'b001:  size_in = SZ_H;
                default: size_in = SZ_W;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b100: size_in = SZ_B;
                3'b001, 3'b101: size_in = SZ_H;
                default:        size_in = SZ_W;
            endcase
        end
        uns_in   = !req_wen && req_funct3[2];
        misal_in = ((size_in == SZ_W) && (req_addr[1:0] != 2'b00)) ||
                   ((size_in == SZ_H) && req_addr[0]);
    end

    // Lane replication: byte stores copy byte 0 everywhere, half stores copy
    // the low half into both halves, word stores pass straight through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_comb begin
                case (size_in)
                    SZ_B:    wdata_aligned[8*gi +: 8] = req_wdata[7:0];
                    SZ_H:    wdata_aligned[8*gi +: 8] = req_wdata[8*(gi % 2) +: 8];
                    default: wdata_aligned[8*gi +: 8] = req_wdata[8*gi +: 8];
                endcase
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
            wen_reg   <= 1'b0;
            size_reg  <= SZ_W;
            uns_reg   <= 1'b0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            wstrb_reg <= wstrb_next;
            wen_reg   <= wen_next;
            size_reg  <= size_next;
            uns_reg   <= uns_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        wstrb_next = wstrb_reg;
        wen_next   = wen_reg;
        size_next  = size_reg;
        uns_next   = uns_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid && (req_wen || req_ren)) begin
                    addr_next  = req_addr;
                    wdata_next = wdata_aligned;
                    wstrb_next = req_wstrobe;
                    wen_next   = req_wen;
                    size_next  = size_in;
                    uns_next   = uns_in;
                    rdata_next = '0;
                    cnt_next   = '0;
                    err_next   = misal_in;
                    state_next = misal_in ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // mem_ready wins over a simultaneous timeout.
                if (mem_ready) begin
                    rdata_next = wen_reg ? 32'd0 : mem_rdata;
                    err_next   = 1'b0;
                    state_next = RESP;
                end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Load extraction from the captured word
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    always_comb begin
        byte_sel = rdata_reg[8*addr_reg[1:0] +: 8];
        half_sel = addr_reg[1] ? rdata_reg[31:16] : rdata_reg[15:0];
        case (size_reg)
            SZ_B:    load_ext = {{24{byte_sel[7] & ~uns_reg}}, byte_sel};
            SZ_H:    load_ext = {{16{half_sel[15] & ~uns_reg}}, half_sel};
            default: load_ext = rdata_reg;
        endcase
    end

    // Bus outputs are only driven during ACCESS so they read as zero otherwise.
    assign mem_valid = (state_reg == ACCESS);
    assign mem_addr  = mem_valid ? {addr_reg[31:2], 2'b00} : 32'd0;
    assign mem_we    = mem_valid & wen_reg;
    assign mem_wstrb = mem_valid ? wstrb_reg : 4'd0;
    assign mem_wdata = mem_valid ? wdata_reg : 32'd0;

    assign req_ready = (state_reg == IDLE) && !rst;
    assign busy      = (state_reg != IDLE);
    assign rsp_valid = (state_reg == RESP);
    assign rsp_err   = rsp_valid & err_reg;
    assign rsp_rdata = (rsp_valid && !err_reg && !wen_reg) ? load_ext : 32'd0;

endmodule

// File: tb/tb_lsu_controller.sv
// Testbench for lsu_controller: directed accesses with hand-computed expected
// responses. The driver pushes each expected response into a queue; a separate
// monitor pops and compares whenever rsp_valid is seen.
module tb_lsu_controller;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrobe;
    logic        req_wen;
    logic        req_ren;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    lsu_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrobe(req_wstrobe),
        .req_wen(req_wen), .req_ren(req_ren),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected none at %0t", $time);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                $display("rsp: rdata=0x%08h err=%0b", rsp_rdata, rsp_err);
            end
        end
    end

    // One access. delay < 0 means never assert mem_ready; otherwise mem_ready is
    // driven in ACCESS cycle delay+1. jiggle keeps req_valid high with a changing
    // address while the access is in flight.
    task automatic do_access(
        input string       tag,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  strb,
        input logic        wen,
        input logic        ren,
        input int          delay,
        input logic [31:0] rword,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input logic        misal,
        input logic [31:0] exp_maddr,
        input logic [31:0] exp_wdata,
        input logic        jiggle
    );
        exp_t e;
        int   k;
        int   exp_cnt;
        @(negedge clk);
        check({tag, ":req_ready_idle"}, {31'd0, req_ready}, 32'd1);
        req_funct3  = f3;
        req_addr    = addr;
        req_wdata   = wdata;
        req_wstrobe = strb;
        req_wen     = wen;
        req_ren     = ren;
        req_valid   = 1'b1;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (!jiggle) req_valid = 1'b0;
        if (misal) begin
            @(negedge clk);
            check({tag, ":misal_no_bus"}, {31'd0, mem_valid}, 32'd0);
            check({tag, ":misal_rsp_lat"}, {31'd0, rsp_valid}, 32'd1);
        end else begin
            k = 0;
            while (k < 40) begin
                @(negedge clk);
                if (mem_valid !== 1'b1) break;
                k++;
                check({tag, ":mem_addr"}, mem_addr, exp_maddr);
                check({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
                check({tag, ":mem_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
                check({tag, ":mem_we"}, {31'd0, mem_we}, {31'd0, wen});
                if (jiggle) begin
                    check({tag, ":req_ready_busy"}, {31'd0, req_ready}, 32'd0);
                    req_addr  = $urandom;
                    req_valid = 1'b1;
                end
                mem_rdata = 32'h5A5A_0F0F;
                if (delay >= 0 && k == delay + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = rword;
                    @(posedge clk);
                    #1;
                    mem_ready = 1'b0;
                    mem_rdata = 32'hC3C3_3C3C;
                end
            end
            exp_cnt = (delay < 0) ? TIMEOUT : delay + 1;
            check({tag, ":mem_valid_cycles"}, k, exp_cnt);
            check({tag, ":rsp_lat"}, {31'd0, rsp_valid}, 32'd1);
        end
        check({tag, ":req_ready_resp"}, {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        $display("access %s: f3=%03b addr=0x%08h wen=%0b ren=%0b delay=%0d", tag, f3, addr, wen, ren, delay);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        req_wstrobe = '0; req_wen = 1'b0; req_ren = 1'b0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst:mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst:req_ready", {31'd0, req_ready}, 32'd0);
        check("rst:busy", {31'd0, busy}, 32'd0);
        check("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst:mem_addr", mem_addr, 32'd0);
        check("rst:mem_wdata", mem_wdata, 32'd0);
        check("rst:rsp_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;

        //         tag      f3      addr          wdata         strb     wen ren dly rword         exp_rdata     err  mis  maddr         mwdata        jig
        do_access("sb",    3'b000, 32'h0000_0103, 32'h0000_00AB, 4'b1000, 1, 0, 0, 32'hFFFF_FFFF, 32'h0,        0, 0, 32'h0000_0100, 32'hABAB_ABAB, 0);
        do_access("lh",    3'b001, 32'h0000_0202, 32'h0,        4'b1100, 0, 1, 0, 32'h8001_1234, 32'hFFFF_8001, 0, 0, 32'h0000_0200, 32'h0,        0);
        do_access("lhu",   3'b101, 32'h0000_0202, 32'h0,        4'b1100, 0, 1, 2, 32'h8001_1234, 32'h0000_8001, 0, 0, 32'h0000_0200, 32'h0,        0);
        do_access("lb",    3'b000, 32'h0000_0201, 32'h0,        4'b0010, 0, 1, 1, 32'h8001_1234, 32'h0000_0012, 0, 0, 32'h0000_0200, 32'h0,        0);
        do_access("lb3",   3'b000, 32'h0000_0203, 32'h0,        4'b1000, 0, 1, 0, 32'h8001_1234, 32'hFFFF_FF80, 0, 0, 32'h0000_0200, 32'h0,        0);
        do_access("lbu3",  3'b100, 32'h0000_0203, 32'h0,        4'b1000, 0, 1, 0, 32'h8001_1234, 32'h0000_0080, 0, 0, 32'h0000_0200, 32'h0,        0);
        do_access("lw",    3'b010, 32'h0000_0204, 32'h0,        4'b1111, 0, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 32'h0000_0204, 32'h0,        0);
        do_access("sh",    3'b001, 32'h0000_0102, 32'h1234_ABCD, 4'b1100, 1, 0, 1, 32'h0,        32'h0,        0, 0, 32'h0000_0100, 32'hABCD_ABCD, 0);
        do_access("sw",    3'b010, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 1, 0, 0, 32'h0,        32'h0,        0, 0, 32'h0000_0108, 32'hCAFE_F00D, 0);
        do_access("sw_mis",3'b010, 32'h0000_0101, 32'h1111_2222, 4'b1111, 1, 0, 0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,        0);
        do_access("lh_mis",3'b001, 32'h0000_0201, 32'h0,        4'b0110, 0, 1, 0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,        0);
        do_access("unk_mis",3'b011,32'h0000_0202, 32'h0,        4'b1111, 0, 1, 0, 32'h0,        32'h0,        1, 1, 32'h0,        32'h0,        0);
        do_access("unk_w", 3'b011, 32'h0000_0208, 32'h0,        4'b1111, 0, 1, 0, 32'h8765_4321, 32'h8765_4321, 0, 0, 32'h0000_0208, 32'h0,        0);
        do_access("tmo",   3'b010, 32'h0000_0300, 32'h0,        4'b1111, 0, 1, -1, 32'h0,       32'h0,        1, 0, 32'h0000_0300, 32'h0,        0);
        do_access("tmo16", 3'b010, 32'h0000_0304, 32'h0,        4'b1111, 0, 1, 15, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 0, 32'h0000_0304, 32'h0,     0);
        do_access("jig",   3'b001, 32'h0000_0106, 32'hBEEF_5678, 4'b1100, 1, 0, 5, 32'h0,        32'h0,        0, 0, 32'h0000_0104, 32'h5678_5678, 1);

        // Request with neither enable set is ignored.
        @(negedge clk);
        req_funct3 = 3'b010; req_addr = 32'h400; req_wen = 1'b0; req_ren = 1'b0; req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("noen:busy", {31'd0, busy}, 32'd0);
            check("noen:req_ready", {31'd0, req_ready}, 32'd1);
        end
        req_valid = 1'b0;
        $display("access noen: req_valid without enables ignored");

        // Reset during ACCESS.
        @(negedge clk);
        req_funct3 = 3'b010; req_addr = 32'h500; req_wdata = 32'h0; req_wstrobe = 4'hF;
        req_wen = 1'b0; req_ren = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rstacc:mem_valid_before", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstacc:mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rstacc:busy", {31'd0, busy}, 32'd0);
        check("rstacc:mem_addr", mem_addr, 32'd0);
        check("rstacc:req_ready", {31'd0, req_ready}, 32'd0);
        check("rstacc:rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            check("rstacc:stray_rsp", {31'd0, rsp_valid}, 32'd0);
            check("rstacc:stray_busy", {31'd0, busy}, 32'd0);
        end
        mem_ready = 1'b0;
        $display("access rstacc: reset during ACCESS");

        repeat (2) @(negedge clk);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
